// File: rtl/dadda_product_divider_if.sv
// Handshake bundle for dadda_product_divider.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : divider side (drives in_ready and the result)
// Signals:
//   in_valid/in_ready     operand handshake
//   dividend/divisor      operands
//   out_valid/out_ready   result handshake
//   quotient/remainder    floor(dividend/divisor), dividend mod divisor
//   div_by_zero           divisor was zero for this result
interface dadda_product_divider_if #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/dadda_product_divider.sv
// Sequential restoring divider, one quotient bit per cycle. Recovers the other
// operand of an 8x8 product and doubles as a general divide unit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    dadda_product_divider_if.slave (operand and result handshakes)
// A nonzero divisor takes DIVIDEND_W CALC cycles; a zero divisor goes straight
// to DONE with quotient all ones and remainder = low dividend bits.
module dadda_product_divider #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dadda_product_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DIVISOR_W-1:0]  rem_q;
  // Holds the dividend during CALC; quotient bits shift in from the LSB side.
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic                  dbz_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  // One restoring step: partial remainder widened by one bit for the trial.
  logic [DIVISOR_W:0]    shifted;
  logic                  trial_ok;
  logic [DIVISOR_W-1:0]  rem_next;

  always_comb begin
    shifted  = {rem_q, quo_q[DIVIDEND_W-1]};
    trial_ok = (shifted >= {1'b0, dsr_q});
    // A successful trial always leaves a value below the divisor, so truncating is safe.
    rem_next = trial_ok ? DIVISOR_W'(shifted - {1'b0, dsr_q}) : shifted[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            dsr_q      <= bus.divisor;
            in_ready_q <= 1'b0;
            if (bus.divisor == '0) begin
              quo_q       <= '1;
              rem_q       <= bus.dividend[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              quo_q   <= bus.dividend;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              cnt_q   <= CntW'(DIVIDEND_W);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          quo_q <= {quo_q[DIVIDEND_W-2:0], trial_ok};
          rem_q <= rem_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // in_ready rises only after this edge, so no accept can coincide with it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
